// File: rtl/pixel_frame_writer.sv
// pixel_frame_writer: write-side master for the pixel RAM.
// Takes an 8-bit pixel stream on a valid/ready handshake and writes it
// row-major into a rectangular window (base, width, height, stride) of the
// frame buffer. Addresses advance incrementally; no multiplier is used.
module pixel_frame_writer #(
   parameter int ADDR_W = 18,
   parameter int DATA_W = 8,
   parameter int DIM_W  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [DIM_W-1:0]  width,
   input  logic [DIM_W-1:0]  height,
   input  logic [ADDR_W-1:0] stride,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              s_ready,
   output logic [ADDR_W-1:0] wraddress,
   output logic [DATA_W-1:0] data,
   output logic              wren,
   output logic              busy,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DIM_W-1:0]  width_q, width_d;
   logic [DIM_W-1:0]  height_q, height_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_W-1:0] row_addr_q, row_addr_d;
   logic [DIM_W-1:0]  col_q, col_d;
   logic [DIM_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] wraddress_q, wraddress_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wren_q, wren_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic accept;
   logic last_col;
   logic last_row;

   assign s_ready   = (state_q == S_WRITE);
   assign busy      = (state_q != S_IDLE);
   assign accept    = s_valid && s_ready;
   assign last_col  = (col_q == width_q - DIM_W'(1));
   assign last_row  = (row_q == height_q - DIM_W'(1));
   assign wraddress = wraddress_q;
   assign data      = data_q;
   assign wren      = wren_q;
   assign done      = done_q;
   assign error     = error_q;

   // State register plus all datapath registers; reset abandons any frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         width_q     <= '0;
         height_q    <= '0;
         stride_q    <= '0;
         cur_addr_q  <= '0;
         row_addr_q  <= '0;
         col_q       <= '0;
         row_q       <= '0;
         wraddress_q <= '0;
         data_q      <= '0;
         wren_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         width_q     <= width_d;
         height_q    <= height_d;
         stride_q    <= stride_d;
         cur_addr_q  <= cur_addr_d;
         row_addr_q  <= row_addr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         wraddress_q <= wraddress_d;
         data_q      <= data_d;
         wren_q      <= wren_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   // Next-state and datapath: frame setup, address walk, end-of-frame.
   always_comb begin
      state_d     = state_q;
      width_d     = width_q;
      height_d    = height_q;
      stride_d    = stride_q;
      cur_addr_d  = cur_addr_q;
      row_addr_d  = row_addr_q;
      col_d       = col_q;
      row_d       = row_q;
      wraddress_d = wraddress_q;
      data_d      = data_q;
      wren_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               if (width != '0 && height != '0) begin
                  width_d    = width;
                  height_d   = height;
                  stride_d   = stride;
                  cur_addr_d = base_addr;
                  row_addr_d = base_addr;
                  col_d      = '0;
                  row_d      = '0;
                  state_d    = S_WRITE;
               end else begin
                  error_d = 1'b1;
               end
            end
         end
         S_WRITE: begin
            if (accept) begin
               wren_d      = 1'b1;
               wraddress_d = cur_addr_q;
               data_d      = s_data;
               if (last_col) begin
                  // Next row starts one stride after the current row start,
                  // independent of how far the column walk went.
                  col_d      = '0;
                  row_d      = row_q + DIM_W'(1);
                  row_addr_d = row_addr_q + stride_q;
                  cur_addr_d = row_addr_q + stride_q;
                  if (last_row) begin
                     state_d = S_DONE;
                     done_d  = 1'b1;
                  end
               end else begin
                  col_d      = col_q + DIM_W'(1);
                  cur_addr_d = cur_addr_q + ADDR_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer: directed frames with randomized pixel data,
// handshake gaps and parameter scrambling, checked against an expected write
// list computed from base + row*stride + col.
module tb_pixel_frame_writer;

   localparam int ADDR_W = 18;
   localparam int DATA_W = 8;
   localparam int DIM_W  = 10;
   localparam logic [31:0] AMASK = 32'h3FFFF;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [DIM_W-1:0]  width = '0;
   logic [DIM_W-1:0]  height = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic              s_valid = 1'b0;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_ready;
   logic [ADDR_W-1:0] wraddress;
   logic [DATA_W-1:0] data;
   logic              wren;
   logic              busy;
   logic              done;
   logic              error;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Model of the held write-port registers.
   logic [ADDR_W-1:0] last_addr = '0;
   logic [DATA_W-1:0] last_data = '0;

   pixel_frame_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
      .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
      .width(width), .height(height), .stride(stride), .s_valid(s_valid),
      .s_data(s_data), .s_ready(s_ready), .wraddress(wraddress), .data(data),
      .wren(wren), .busy(busy), .done(done), .error(error)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input bit e_wren, input bit e_done, input bit e_busy,
                            input bit e_ready, input bit e_err);
      chk("wren", {31'b0, wren}, {31'b0, e_wren});
      chk("done", {31'b0, done}, {31'b0, e_done});
      chk("busy", {31'b0, busy}, {31'b0, e_busy});
      chk("s_ready", {31'b0, s_ready}, {31'b0, e_ready});
      chk("error", {31'b0, error}, {31'b0, e_err});
      chk("wraddress", {14'b0, wraddress}, {14'b0, last_addr});
      chk("data", {24'b0, data}, {24'b0, last_data});
   endtask

   // One frame. vmode: 0 = valid always high, 1 = 1,0,0,1,0,1,1 pattern,
   // 2 = random gaps. poke: fire ignored start pulses during the frame.
   task automatic run_frame(input logic [ADDR_W-1:0] b, input int w, input int h,
                            input logic [ADDR_W-1:0] st, input int vmode,
                            input bit poke, input bit fixed);
      logic [ADDR_W-1:0] ea[$];
      logic [DATA_W-1:0] ed[$];
      int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
      int idx, k, n;
      bit v, last;
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++) begin
            ea.push_back(ADDR_W'((32'(b) + r * 32'(st) + c) & AMASK));
            ed.push_back(fixed ? DATA_W'(8'hAA + 8'h11 * ed.size()) : DATA_W'($urandom));
         end
      n = w * h;
      start = 1'b1; base_addr = b; width = DIM_W'(w); height = DIM_W'(h); stride = st;
      s_valid = 1'(($urandom % 2)); s_data = DATA_W'($urandom);
      @(posedge clock); #1;
      start = 1'b0;
      base_addr = ADDR_W'($urandom); width = DIM_W'($urandom); height = DIM_W'($urandom);
      stride = ADDR_W'($urandom);
      check_out(0, 0, 1, 1, 0);
      idx = 0; k = 0;
      while (idx < n && k < 2000) begin
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[k % 7][0] : (($urandom % 3) != 0);
         s_valid = v;
         s_data = v ? ed[idx] : DATA_W'($urandom);
         if (poke && ($urandom % 3 == 0)) begin
            start = 1'b1; base_addr = ADDR_W'($urandom); width = DIM_W'(1); height = DIM_W'(1);
         end
         @(posedge clock); #1;
         start = 1'b0; s_valid = 1'b0;
         if (v) begin
            last_addr = ea[idx]; last_data = ed[idx];
            idx++;
            last = (idx == n);
            check_out(1, last, 1, !last, 0);
         end else begin
            check_out(0, 0, 1, 1, 0);
         end
         k++;
      end
      if (idx < n) chk("frame_timeout", 32'(idx), 32'(n));
      // Held valid after the frame must not be consumed.
      s_valid = 1'b1; s_data = DATA_W'($urandom);
      @(posedge clock); #1;
      check_out(0, 0, 0, 0, 0);
      @(posedge clock); #1;
      s_valid = 1'b0;
      check_out(0, 0, 0, 0, 0);
   endtask

   task automatic zero_dim(input int w, input int h);
      start = 1'b1; width = DIM_W'(w); height = DIM_W'(h);
      base_addr = ADDR_W'($urandom); s_valid = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check_out(0, 0, 0, 0, 1);
      @(posedge clock); #1;
      s_valid = 1'b0;
      check_out(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      #1;
      check_out(0, 0, 0, 0, 0);
      @(negedge clock); reset = 1'b0;
      @(posedge clock); #1;
      check_out(0, 0, 0, 0, 0);

      // Row-stride frame, continuous valid
      run_frame(18'h00010, 2, 2, 18'd4, 0, 1'b0, 1'b1);
      // Same frame with gaps
      run_frame(18'h00010, 2, 2, 18'd4, 1, 1'b0, 1'b1);
      // Zero dimensions
      zero_dim(0, 5);
      zero_dim(7, 0);
      // Wrap-around
      run_frame(18'h3FFFF, 2, 1, 18'd0, 0, 1'b0, 1'b0);

      // Reset mid-frame after 5 accepts of a 4x4 frame
      begin
         logic [ADDR_W-1:0] b;
         b = ADDR_W'($urandom);
         start = 1'b1; base_addr = b; width = DIM_W'(4); height = DIM_W'(4); stride = 18'd16;
         @(posedge clock); #1;
         start = 1'b0;
         check_out(0, 0, 1, 1, 0);
         for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = DATA_W'($urandom);
            last_data = s_data;
            last_addr = ADDR_W'((32'(b) + (i / 4) * 16 + (i % 4)) & AMASK);
            @(posedge clock); #1;
            check_out(1, 0, 1, 1, 0);
         end
         s_valid = 1'b0;
         #1 reset = 1'b1;
         #1;
         last_addr = '0; last_data = '0;
         check_out(0, 0, 0, 0, 0);
         @(negedge clock); reset = 1'b0;
         run_frame(18'h01234, 4, 4, 18'd8, 2, 1'b0, 1'b0);
      end

      // Start while busy is ignored
      run_frame(18'h00200, 3, 3, 18'd5, 2, 1'b1, 1'b0);

      // Randomized frames: overlapping/zero strides, width or height of 1
      for (int f = 0; f < 8; f++)
         run_frame(ADDR_W'($urandom), 1 + int'($urandom % 5), 1 + int'($urandom % 4),
                   ADDR_W'($urandom % 7), 2, 1'(($urandom % 2)), 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/pixel_frame_writer.md
Name: pixel_frame_writer

Overview:
- Write-side master for the pixel RAM (RAM_pixels write port: wraddress/data/wren).
- Accepts an 8-bit pixel stream over a valid/ready handshake.
- Places pixels row-major into a rectangular window of the frame buffer, defined by base address, width, height and row stride.
- Sits between the pixel source (loader/UART or processing core) and the RAM; the RAM's read port is consumed by downstream blocks.

Parameters:
ADDR_W, 18, RAM address width (matches wraddress)
DATA_W, 8, pixel width (matches data)
DIM_W, 10, width/height field width

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
base_addr  in  ADDR_W  address of pixel (0,0); latched on accepted start
width  in  DIM_W  pixels per row; latched on accepted start
height  in  DIM_W  rows per frame; latched on accepted start
stride  in  ADDR_W  address distance between row starts; latched on accepted start
s_valid  in  1  source has a pixel on s_data
s_data  in  DATA_W  pixel value
s_ready  out  1  writer accepts a pixel this cycle
wraddress  out  ADDR_W  RAM write address (registered)
data  out  DATA_W  RAM write data (registered)
wren  out  1  RAM write enable (registered)
busy  out  1  frame in progress
done  out  1  one-cycle pulse: frame complete
error  out  1  one-cycle pulse: start rejected

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and latched parameters 0.
- Reset is asynchronous, so asserting it mid-frame abandons the frame. RAM contents already written stay written. No done is issued.
- States:
  - IDLE: s_ready=0, busy=0.
    - start=1 with width!=0 and height!=0: latch base_addr, width, height and stride; set cur_addr=row_addr=base_addr, col=0, row=0; go to WRITE.
    - start=1 with width==0 or height==0: error=1 on the next cycle; remain IDLE.
  - WRITE: busy=1, s_ready=1 (combinational from state).
    - An accept is s_valid&&s_ready.
    - On an accept, next cycle: wren=1, wraddress=cur_addr, data=s_data. Latency is exactly 1 cycle from accept to write.
    - Cycles without an accept drive wren=0. wraddress and data hold their last values.
    - Within a row (accept with col!=width-1): col+1, cur_addr+1.
    - End of row (accept with col==width-1): col=0, row+1, row_addr+=stride, cur_addr=row_addr+stride.
    - Last pixel (accept with col==width-1 and row==height-1): go to DONE. s_ready is 0 in the following cycle.
  - DONE: busy=1, s_ready=0.
    - done=1 for this single cycle. It coincides with the wren of the last pixel.
    - Next state: IDLE.
- Arithmetic:
  - All address adds are modulo 2^ADDR_W; addresses wrap past 0x3FFFF to 0x00000 with no error.
  - No multiplier; addresses are incremental only.
  - Counters are DIM_W bits; width/height up to 2^DIM_W-1.
- start is ignored in WRITE and DONE. It has no effect on the latched parameters. No error is raised.
- Changes to base_addr, width, height and stride after start has been accepted have no effect on the current frame.
- s_data is sampled only on an accept. Holding s_valid=1 through the DONE/IDLE cycles does not consume data.
- stride<width is legal; rows overlap and later pixels overwrite earlier ones.
- stride=0 is legal; every row rewrites the same addresses.
- width=1: every accept is an end-of-row.
- height=1: frame ends after width accepts.

Test Plan:
1. Row-stride frame: base=0x00010, width=2, height=2, stride=4; pixels AA,BB,CC,DD sent with s_valid continuously high -> wren pulses at addresses 0x10,0x11,0x14,0x15 with data AA,BB,CC,DD on 4 consecutive cycles. done=1 in the same cycle as the DD write. busy falls the next cycle. Read-back through a RAM_pixels instance returns the same values.
2. Backpressure/gaps: same frame with s_valid toggling 1,0,0,1,0,1,1 -> exactly 4 writes, each 1 cycle after its accept, with wren=0 in gap cycles. Addresses and data are identical to scenario 1.
3. Zero dimension: start with width=0, height=5 -> error=1 for one cycle, busy stays 0, no wren. Repeat with height=0 for the same result.
4. Wrap-around: base=0x3FFFF, width=2, height=1 -> writes to 0x3FFFF then 0x00000. done=1 with the second write.
5. Reset mid-frame: width=4, height=4; assert reset after 5 accepts -> asynchronously busy=0, wren=0, s_ready=0, with no done. A new start then writes from the new base_addr, with col and row counters restarted.
6. Start while busy: second start pulse with different base_addr during WRITE -> ignored. The frame completes at the original addresses, with no error.
